// File: rtl/multi_tick_divider.sv
// Bank of independent programmable tick dividers with a per-channel pending divisor slot.
// Optional square-wave outputs are built only when TICK_SQUARE_OUT_EN is defined.
module multi_tick_divider #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 30,
  parameter int RST_DIV = 0,
  localparam int LCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [LCH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic              load_ready,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              restart,
  output logic [NUM_CH-1:0] tick
`ifdef TICK_SQUARE_OUT_EN
  ,
  output logic [NUM_CH-1:0] sq_out
`endif
);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  act_div  [NUM_CH];
  logic [CNT_W-1:0]  pend_div [NUM_CH];
  logic [NUM_CH-1:0] pend_flag;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] load_hit;
  logic [NUM_CH-1:0] term;

  // Handshake: a write transfers on a cycle where load_valid && load_ready.
  // load_ready drops only while the addressed channel already holds a pending
  // divisor; writes to channels that do not exist are accepted and discarded.
  always_comb begin
    load_ready = 1'b1;
    load_hit   = '0;
    term       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(load_ch) == i) begin
        load_ready  = !pend_flag[i];
        load_hit[i] = load_valid && !pend_flag[i];
      end
      term[i] = ch_en[i] && (cnt[i] == act_div[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        act_div[i]  <= CNT_W'(RST_DIV);
        pend_div[i] <= '0;
      end
      pend_flag <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (restart) begin
          // A write landing together with restart bypasses the pending slot.
          cnt[i]       <= '0;
          tick_q[i]    <= 1'b0;
          pend_flag[i] <= 1'b0;
          if (load_hit[i]) begin
            act_div[i] <= load_div;
          end else if (pend_flag[i]) begin
            act_div[i] <= pend_div[i];
          end
        end else begin
          tick_q[i] <= term[i];
          if (term[i]) begin
            cnt[i] <= '0;
            if (pend_flag[i]) begin
              act_div[i]   <= pend_div[i];
              pend_flag[i] <= 1'b0;
            end
          end else if (ch_en[i]) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
          // load_hit implies the slot was empty, so this never collides with
          // the wrap-time copy above; a same-cycle write waits for the next wrap.
          if (load_hit[i]) begin
            pend_div[i]  <= load_div;
            pend_flag[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign tick = tick_q;

`ifdef TICK_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q <= '0;
    end else if (restart) begin
      sq_q <= '0;
    end else begin
      sq_q <= sq_q ^ term;
    end
  end

  assign sq_out = sq_q;
`endif

endmodule

// File: tb/tb_multi_tick_divider.sv
// Self-checking bench for multi_tick_divider (NUM_CH=4, CNT_W=8, RST_DIV=0).
// Define TICK_SQUARE_OUT_EN for both bench and RTL to exercise the square-wave outputs.
module tb_multi_tick_divider;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int RST_DIV = 0;

  logic              clk;
  logic              rst_n;
  logic              load_valid;
  logic [1:0]        load_ch;
  logic [CNT_W-1:0]  load_div;
  logic              load_ready;
  logic [NUM_CH-1:0] ch_en;
  logic              restart;
  logic [NUM_CH-1:0] tick;
`ifdef TICK_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_out;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [NUM_CH-1:0] exp_q[$];

  multi_tick_divider #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .RST_DIV(RST_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ch   (load_ch),
    .load_div  (load_div),
    .load_ready(load_ready),
    .ch_en     (ch_en),
    .restart   (restart),
    .tick      (tick)
`ifdef TICK_SQUARE_OUT_EN
    ,
    .sq_out    (sq_out)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired, required finish before 2ms");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 1'b0; load_ch = '0; load_div = '0;
    ch_en = '0; restart = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tick !== 4'b0000) begin
      n_err++; $display("FAIL reset_tick: got %b required 0000", tick);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      load_ch = 2'(c);
      #1;
      n_cmp++;
      if (load_ready !== 1'b1) begin
        n_err++; $display("FAIL reset_ready ch%0d: got %b required 1", c, load_ready);
      end
    end
    load_ch = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Write div 3 to ch0, apply it with restart, then only ch0 counts.
  task automatic test_basic();
    logic [NUM_CH-1:0] e;
    @(negedge clk);
    load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd3; ch_en = '0;
    #1; n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_ready_first: got %b required 1", load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0; restart = 1'b1;
    #1; n_cmp++;
    if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_ready_pending: got %b required 0", load_ready);
    end
    @(negedge clk);
    restart = 1'b0; ch_en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back({3'b000, (k % 4) == 0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (tick !== e) begin
        n_err++; $display("FAIL basic_tick k=%0d: got %b required %b", k, tick, e);
      end
    end
    ch_en = '0;
  endtask

  // Mid-period write to ch1, then a second write blocked by the full slot.
  task automatic test_pending();
    logic [NUM_CH-1:0] e;
    @(negedge clk);
    load_valid = 1'b1; load_ch = 2'd1; load_div = 8'd3;
    @(negedge clk);
    load_valid = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; ch_en = 4'b0010;
    for (int k = 1; k <= 24; k++) begin
      if (k == 3) begin
        load_valid = 1'b1; load_div = 8'd9;
        #1; n_cmp++;
        if (load_ready !== 1'b1) begin
          n_err++; $display("FAIL pend_ready_first: got %b required 1", load_ready);
        end
      end
      if (k == 4) begin
        load_div = 8'd7;
        #1; n_cmp++;
        if (load_ready !== 1'b0) begin
          n_err++; $display("FAIL pend_ready_second: got %b required 0", load_ready);
        end
      end
      if (k == 5) begin
        load_valid = 1'b0;
        #1; n_cmp++;
        if (load_ready !== 1'b1) begin
          n_err++; $display("FAIL pend_ready_after_wrap: got %b required 1", load_ready);
        end
      end
      exp_q.push_back({2'b00, (k == 4 || k == 14 || k == 24), 1'b0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (tick !== e) begin
        n_err++; $display("FAIL pend_tick k=%0d: got %b required %b", k, tick, e);
      end
    end
    ch_en = '0;
  endtask

  // Full-range divisor on ch2 and divisor 0 on ch3.
  task automatic test_wrap();
    logic [NUM_CH-1:0] e;
    @(negedge clk);
    load_valid = 1'b1; load_ch = 2'd2; load_div = 8'd255;
    @(negedge clk);
    load_ch = 2'd3; load_div = 8'd0;
    @(negedge clk);
    load_valid = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; ch_en = 4'b1100;
    for (int k = 1; k <= 520; k++) begin
      exp_q.push_back({1'b1, (k % 256) == 0, 2'b00});
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (tick !== e) begin
        n_err++; $display("FAIL wrap_tick k=%0d: got %b required %b", k, tick, e);
      end
    end
    ch_en = '0;
  endtask

  // Pending div 5 on ch0 applied by restart; ch1 paused for 7 cycles; late restart kills a tick.
  task automatic test_restart_hold();
    logic [NUM_CH-1:0] e;
    @(negedge clk);
    load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd5;
    @(negedge clk);
    load_valid = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      ch_en = {2'b00, !(k >= 13 && k <= 19), 1'b1};
      restart = (k == 42);
      exp_q.push_back({2'b00, (k == 10 || k == 27 || k == 37), ((k % 6) == 0) && (k != 42)});
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (tick !== e) begin
        n_err++; $display("FAIL hold_tick k=%0d: got %b required %b", k, tick, e);
      end
    end
    restart = 1'b0; ch_en = '0;
  endtask

  // Async reset mid-period with a pending write on ch0.
  task automatic test_reset_mid();
    logic [NUM_CH-1:0] e;
    ch_en = 4'b1001;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd7;
      end
      exp_q.push_back(4'b1000);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (tick !== e) begin
        n_err++; $display("FAIL rmid_pre k=%0d: got %b required %b", k, tick, e);
      end
    end
    load_valid = 1'b0;
    #1; n_cmp++;
    if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_pending: got %b required 0", load_ready);
    end
    #1 rst_n = 1'b0;
    #1; n_cmp++;
    if (tick !== 4'b0000) begin
      n_err++; $display("FAIL rmid_tick_async: got %b required 0000", tick);
    end
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++; $display("FAIL rmid_pending_cleared: got %b required 1", load_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(4'b1001);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (tick !== e) begin
        n_err++; $display("FAIL rmid_post k=%0d: got %b required %b", k, tick, e);
      end
    end
    ch_en = '0;
  endtask

`ifdef TICK_SQUARE_OUT_EN
  task automatic test_square();
    logic [NUM_CH-1:0] e;
    @(negedge clk);
    load_valid = 1'b1; load_ch = 2'd2; load_div = 8'd4;
    @(negedge clk);
    load_valid = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; ch_en = 4'b0100;
    n_cmp++;
    if (sq_out !== 4'b0000) begin
      n_err++; $display("FAIL sq_restart: got %b required 0000", sq_out);
    end
    for (int k = 1; k <= 22; k++) begin
      exp_q.push_back({1'b0, ((k / 5) % 2) == 1, 2'b00});
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (sq_out !== e) begin
        n_err++; $display("FAIL sq_out k=%0d: got %b required %b", k, sq_out, e);
      end
    end
    ch_en = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_wrap();
    test_restart_hold();
    test_reset_mid();
`ifdef TICK_SQUARE_OUT_EN
    test_square();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
